// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
// Also holds the small PC helper used by the prefetcher.
package ifu_prefetch_pkg;

  localparam int          IFU_DEPTH     = 4;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
  localparam int          IFU_IM_ADDR_W = 10;
  localparam int          IFU_ENTRY_W   = 64;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between imem responses and decode.
// The head entry is read straight from storage, so the data is available in the same cycle.
module ifu_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is reset so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: sequential imem fetch with in-flight credit tracking,
// a {pc,instr} FIFO toward decode, and redirect flush/squash of the old stream.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          DEPTH     = IFU_DEPTH,
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter int          IM_ADDR_W = IFU_IM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [IM_ADDR_W-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc,
  input  logic                 id_ready,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]          fetch_pc;
  logic [31:0]          resp_pc;
  logic [31:0]          target_pc;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        discard;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 gnt_fire;
  logic                 drop;
  logic                 push;
  logic                 pop;
  logic [IFU_ENTRY_W-1:0] head;

  // Kept in-flight responses plus buffered entries may never exceed the FIFO size,
  // which is what lets a response always be accepted without back-pressure.
  assign occupancy = {1'b0, count} + {1'b0, inflight} - {1'b0, discard};
  assign imem_req  = rst && !redirect_valid && (inflight < CW'(DEPTH))
                   && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc[IM_ADDR_W+1:2];
  assign target_pc = pc_align(redirect_pc);

  assign gnt_fire = imem_req && imem_gnt;
  assign drop     = imem_rvalid && (discard != '0);
  assign push     = imem_rvalid && !drop && !redirect_valid;
  assign if_valid = (count != '0) && !redirect_valid;
  assign pop      = if_valid && id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(gnt_fire) - CW'(imem_rvalid);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= inflight - CW'(imem_rvalid);
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        if (drop)     discard  <= discard - CW'(1);
      end
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (IFU_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (head),
    .count (count)
  );

  assign if_pc    = head[63:32];
  assign if_instr = head[31:0];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order latency-programmable imem model
// and a scoreboard of granted fetch PCs compared at every decode pop.
module tb_ifu_prefetch;

  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          id_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;

  ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h0), .IM_ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 0;
  int          ngnt = 0;
  int          phase_start = 0;
  logic        last_valid;
  logic [31:0] mdl_pc;
  req_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] popped[$];
  int          popped_cyc[$];

  function automatic logic [31:0] img(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {a, 6'h15, ~a, 6'h2A};
  endfunction

  function automatic logic [63:0] pop_pc(input int i);
    if (i < popped.size()) return {32'h0, popped[i]};
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic [63:0] pop_cyc(input int i);
    if (i < popped_cyc.size()) return 64'(popped_cyc[i] - phase_start);
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic [31:0] pc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = img(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    last_valid = if_valid;
    if (redirect_valid) begin
      chk("req_in_redirect", {63'h0, imem_req}, 64'h0);
      chk("valid_in_redirect", {63'h0, if_valid}, 64'h0);
      exp_q.delete();
      mdl_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (imem_req && imem_gnt) begin
      chk("imem_addr", {54'h0, imem_addr}, {54'h0, mdl_pc[AW+1:2]});
      pend.push_back('{addr: mdl_pc[AW+1:2], due: cyc + 1 + lat});
      exp_q.push_back(mdl_pc);
      mdl_pc = mdl_pc + 32'd4;
      ngnt++;
    end
    if (if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", {32'h0, if_pc}, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        pc = exp_q.pop_front();
        chk("if_pc", {32'h0, if_pc}, {32'h0, pc});
        chk("if_instr", {32'h0, if_instr}, {32'h0, img(pc[AW+1:2])});
      end
      popped.push_back(if_pc);
      popped_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic new_phase();
    popped.delete();
    popped_cyc.delete();
    phase_start = cyc;
  endtask

  initial begin
    logic old_seen;
    rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mdl_pc = 32'h0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_imem_req", {63'h0, imem_req}, 64'h0);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_if_instr", {32'h0, if_instr}, 64'h0);
    chk("rst_if_pc", {32'h0, if_pc}, 64'h0);
    chk("rst_imem_addr", {54'h0, imem_addr}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming with next-cycle imem and a ready decode stage
    new_phase();
    lat = 0;
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    ticks(12);
    chk("t1_first_pop_cycle", pop_cyc(0), 64'd2);
    chk("t1_first_pc", pop_pc(0), 64'h0);
    chk("t1_throughput", 64'(popped.size()), 64'd10);

    // Decode stalled: credit limit stops requests at DEPTH
    id_ready = 1'b0;
    redirect(32'h0);
    ngnt = 0;
    ticks(10);
    chk("t2_grants", 64'(ngnt), 64'd4);
    chk("t2_req_stalled", {63'h0, imem_req}, 64'h0);
    chk("t2_head_valid", {63'h0, if_valid}, 64'h1);
    chk("t2_head_pc", {32'h0, if_pc}, 64'h0);
    new_phase();
    id_ready = 1'b1;
    ticks(12);
    chk("t2_pop3_pc", pop_pc(3), 64'hC);
    chk("t2_resume", pop_pc(4), 64'h10);

    // Long latency, four in flight, then redirect squashes them
    lat = 3;
    redirect(32'h10);
    ticks(4);
    redirect(32'h40);
    new_phase();
    ticks(20);
    chk("t3_first_pc", pop_pc(0), 64'h40);
    old_seen = 1'b0;
    foreach (popped[i]) if (popped[i] >= 32'h10 && popped[i] <= 32'h1C) old_seen = 1'b1;
    chk("t3_no_old_stream", {63'h0, old_seen}, 64'h0);

    // Redirect coinciding with a response and a would-be pop
    lat = 1;
    ticks(8);
    chk("t4_pre_valid", {63'h0, last_valid}, 64'h1);
    redirect(32'h200);
    new_phase();
    tick();
    chk("t4_empty_after", {63'h0, last_valid}, 64'h0);
    ticks(10);
    chk("t4_first_pc", pop_pc(0), 64'h200);
    chk("t4_second_pc", pop_pc(1), 64'h204);

    // Unaligned target near the top of the address space wraps to zero
    lat = 0;
    redirect(32'hFFFF_FFFE);
    new_phase();
    ticks(6);
    chk("t5_top_pc", pop_pc(0), 64'hFFFF_FFFC);
    chk("t5_wrap_pc", pop_pc(1), 64'h0);

    // Asynchronous reset in the middle of a stalled stream
    lat = 2;
    id_ready = 1'b0;
    redirect(32'h100);
    ticks(5);
    chk("t6_pre_valid", {63'h0, if_valid}, 64'h1);
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_imem_req", {63'h0, imem_req}, 64'h0);
    chk("t6_if_valid", {63'h0, if_valid}, 64'h0);
    chk("t6_if_pc", {32'h0, if_pc}, 64'h0);
    chk("t6_if_instr", {32'h0, if_instr}, 64'h0);
    chk("t6_imem_addr", {54'h0, imem_addr}, 64'h0);
    pend.delete();
    exp_q.delete();
    mdl_pc = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    lat = 0;
    id_ready = 1'b1;
    new_phase();
    ticks(8);
    chk("t6_restart_pc", pop_pc(0), 64'h0);
    chk("t6_restart_cycle", pop_cyc(0), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
